// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes 16-bit words into instruction memory from address 0 and releases the CPU on success.
module prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [15:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      r_state;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [7:0]  r_cks;
    logic [7:0]  r_hi;

    logic        w_acc;
    logic [15:0] w_len;
    logic        w_start_ok;

    assign w_acc      = in_valid && in_ready;
    assign w_len      = {r_len[15:8], in_data};
    assign w_start_ok = start && (r_state == IDLE || r_state == DONE || r_state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_cks      <= '0;
            r_hi       <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // The checksum byte itself is compared, not folded into the accumulator
            if (w_acc && r_state != CHECK)
                r_cks <= r_cks ^ in_data;

            if (w_start_ok) begin
                r_state   <= LEN_HI;
                r_cks     <= '0;
                r_idx     <= '0;
                done      <= 1'b0;
                error     <= 1'b0;
                cpu_reset <= 1'b1;
                in_ready  <= 1'b1;
            end else begin
                case (r_state)
                    LEN_HI: if (w_acc) begin
                        r_len[15:8] <= in_data;
                        r_state     <= LEN_LO;
                    end
                    LEN_LO: if (w_acc) begin
                        r_len <= w_len;
                        if ({1'b0, w_len} > DEPTH_W) begin
                            r_state  <= ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            r_state <= CHECK;
                        end else begin
                            r_state <= DATA_HI;
                        end
                    end
                    DATA_HI: if (w_acc) begin
                        r_hi    <= in_data;
                        r_state <= DATA_LO;
                    end
                    DATA_LO: if (w_acc) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= r_idx[ADDR_WIDTH-1:0];
                        imem_wdata <= {r_hi, in_data};
                        r_idx      <= r_idx + 16'd1;
                        r_state    <= (r_idx == r_len - 16'd1) ? CHECK : DATA_HI;
                    end
                    CHECK: if (w_acc) begin
                        in_ready <= 1'b0;
                        if (r_cks == in_data) begin
                            r_state   <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            error   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares each imem_we pulse.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    prog_loader #(.ADDR_WIDTH(8), .DEPTH(256)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
    wr_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", 32'(imem_wdata), 32'(e.data));
            end
        end
    end

    task automatic expect_wr(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("post_start_in_ready", 32'(in_ready), 1);
        check("post_start_cpu_reset", 32'(cpu_reset), 1);
        check("post_start_done", 32'(done), 0);
        check("post_start_error", 32'(error), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        int   t;
        repeat (gap) begin @(posedge clk); #1; end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            t++;
            if (t > 50) begin
                check("handshake_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'hxx;
    endtask

    task automatic send_stream(input logic [7:0] bytes[$], input int maxgap);
        foreach (bytes[i]) send_byte(bytes[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_final(input string tag, input logic d, input logic e, input logic cr);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
        check({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    logic [7:0] good[$]  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    logic [7:0] bad[$]   = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    logic [7:0] big[$]   = '{8'h01, 8'h01};
    logic [7:0] zok[$]   = '{8'h00, 8'h00, 8'h00};
    logic [7:0] zbad[$]  = '{8'h00, 8'h00, 8'h01};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", 32'(imem_wdata), 0);
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // N=2, continuous valid: done and cpu_reset release right after the checksum accept
        expect_wr(8'h00, 16'h1234);
        expect_wr(8'h01, 16'hABCD);
        pulse_start();
        foreach (good[i]) send_byte(good[i], 0);
        check_final("n2", 1, 0, 0);
        check("n2_drained", exp_q.size(), 0);
        @(posedge clk); #1;

        // Same stream with random valid gaps
        expect_wr(8'h00, 16'h1234);
        expect_wr(8'h01, 16'hABCD);
        pulse_start();
        send_stream(good, 3);
        check_final("gaps", 1, 0, 0);

        // Bad checksum: writes still happen, then error
        expect_wr(8'h00, 16'h1234);
        expect_wr(8'h01, 16'hABCD);
        pulse_start();
        send_stream(bad, 0);
        check_final("badck", 0, 1, 1);

        expect_wr(8'h00, 16'h1234);
        expect_wr(8'h01, 16'hABCD);
        pulse_start();
        send_stream(good, 1);
        check_final("recover", 1, 0, 0);

        // N=257 exceeds DEPTH
        pulse_start();
        send_byte(big[0], 0);
        send_byte(big[1], 0);
        check_final("ovf", 0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_still_error", 32'(error), 1);

        // N=0
        pulse_start();
        send_stream(zok, 0);
        check_final("n0ok", 1, 0, 0);
        pulse_start();
        send_stream(zbad, 0);
        check_final("n0bad", 0, 1, 1);

        // Reset while in DATA_LO after word 0 has been written
        expect_wr(8'h00, 16'h1234);
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(good[i], 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_in_ready", 32'(in_ready), 0);
        check("mid_rst_imem_we", 32'(imem_we), 0);
        check("mid_rst_imem_addr", 32'(imem_addr), 0);
        check("mid_rst_imem_wdata", 32'(imem_wdata), 0);
        check("mid_rst_cpu_reset", 32'(cpu_reset), 1);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_error", 32'(error), 0);
        reset = 1'b0;
        in_data = 8'hCD;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mid_rst_drained", exp_q.size(), 0);

        expect_wr(8'h00, 16'h1234);
        expect_wr(8'h01, 16'hABCD);
        pulse_start();
        send_stream(good, 2);
        check_final("after_rst", 1, 0, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
